// File: rtl/alu.sv
// alu -- registered 8-bit arithmetic/logic unit for the execute stage.
//
// Each rising edge of clk samples opcode, a and b and registers the result
// on y, together with a zero flag (y == 0) and a signed-overflow flag.
// The latency is one cycle. There is no handshake and no enable.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset (y=0, zero=1, overflow=0)
//   opcode    in   4      operation select (all 16 codes defined)
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B; b[$clog2(WIDTH)-1:0] is the shift/rotate amount
//   y         out  WIDTH  registered result
//   zero      out  1      registered, 1 when y == 0
//   overflow  out  1      registered overflow flag (ADD/SUB signed, MUL unsigned)
//
// Build option:
//   ALU_SAT_EN  when defined, ADD/SUB saturate to the most positive or most
//               negative value on signed overflow, and MUL saturates to all-ones
//               when the product does not fit. zero follows the saturated result.

module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_NAND = 4'd6,
    OP_XNOR = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SAR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_SLT  = 4'd13,
    OP_SLTU = 4'd14,
    OP_MUL  = 4'd15
  } op_e;

  // Signed saturation for ADD/SUB. On overflow the true result carries the
  // sign of a (both operands share it for ADD; for SUB it is a's sign), so
  // neg selects the most negative value, otherwise the most positive.
  function automatic logic [WIDTH-1:0] sat_signed(
    input logic [WIDTH-1:0] wrapped,
    input logic             ovf,
    input logic             neg
  );
    if (SAT_EN && ovf) begin
      return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return wrapped;
  endfunction

  // Unsigned saturation for MUL: all-ones when the product overflowed.
  function automatic logic [WIDTH-1:0] sat_unsigned(
    input logic [WIDTH-1:0] wrapped,
    input logic             ovf
  );
    if (SAT_EN && ovf) begin
      return {WIDTH{1'b1}};
    end
    return wrapped;
  endfunction

  op_e                    op_p0;
  logic signed [WIDTH-1:0] a_s_p0;
  logic signed [WIDTH-1:0] b_s_p0;
  logic [SH_W-1:0]        sh_p0;
  logic [WIDTH-1:0]       sum_p0;
  logic [WIDTH-1:0]       diff_p0;
  logic                   add_ovf_p0;
  logic                   sub_ovf_p0;
  logic [2*WIDTH-1:0]     prod_p0;
  logic                   mul_ovf_p0;
  logic [2*WIDTH-1:0]     rol_p0;
  logic [2*WIDTH-1:0]     ror_p0;
  logic [WIDTH-1:0]       res_p0;
  logic                   ovf_p0;
  logic                   zero_p0;

  logic [WIDTH-1:0]       y_p1;
  logic                   zero_p1;
  logic                   ovf_p1;

  // ---- stage p0: combinational execute on the presented operands ----
  assign op_p0  = op_e'(opcode);
  assign a_s_p0 = a;
  assign b_s_p0 = b;
  assign sh_p0  = b[SH_W-1:0];

  assign sum_p0     = a + b;
  assign diff_p0    = a - b;
  assign add_ovf_p0 = (a_s_p0[WIDTH-1] == b_s_p0[WIDTH-1]) &&
                      (sum_p0[WIDTH-1] != a_s_p0[WIDTH-1]);
  assign sub_ovf_p0 = (a_s_p0[WIDTH-1] != b_s_p0[WIDTH-1]) &&
                      (diff_p0[WIDTH-1] != a_s_p0[WIDTH-1]);

  assign prod_p0    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign mul_ovf_p0 = |prod_p0[2*WIDTH-1:WIDTH];

  // Rotates via a doubled operand: the bits shifted out of one copy are
  // refilled from the other, so the wanted window is one half of the result.
  assign rol_p0 = {a, a} << sh_p0;
  assign ror_p0 = {a, a} >> sh_p0;

  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    case (op_p0)
      OP_ADD: begin
        ovf_p0 = add_ovf_p0;
        res_p0 = sat_signed(sum_p0, add_ovf_p0, a_s_p0[WIDTH-1]);
      end
      OP_SUB: begin
        ovf_p0 = sub_ovf_p0;
        res_p0 = sat_signed(diff_p0, sub_ovf_p0, a_s_p0[WIDTH-1]);
      end
      OP_AND:  res_p0 = a & b;
      OP_OR:   res_p0 = a | b;
      OP_XOR:  res_p0 = a ^ b;
      OP_NOR:  res_p0 = ~(a | b);
      OP_NAND: res_p0 = ~(a & b);
      OP_XNOR: res_p0 = ~(a ^ b);
      OP_SHL:  res_p0 = a << sh_p0;
      OP_SHR:  res_p0 = a >> sh_p0;
      OP_SAR:  res_p0 = a_s_p0 >>> sh_p0;
      OP_ROL:  res_p0 = rol_p0[2*WIDTH-1:WIDTH];
      OP_ROR:  res_p0 = ror_p0[WIDTH-1:0];
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s_p0 < b_s_p0)};
      OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL: begin
        ovf_p0 = mul_ovf_p0;
        res_p0 = sat_unsigned(prod_p0[WIDTH-1:0], mul_ovf_p0);
      end
      default: begin
        res_p0 = '0;
        ovf_p0 = 1'b0;
      end
    endcase
    zero_p0 = (res_p0 == '0);
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1    <= '0;
      zero_p1 <= 1'b1;
      ovf_p1  <= 1'b0;
    end else begin
      y_p1    <= res_p0;
      zero_p1 <= zero_p0;
      ovf_p1  <= ovf_p0;
    end
  end

  assign y        = y_p1;
  assign zero     = zero_p1;
  assign overflow = ovf_p1;

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed and randomized checks of the alu with a result scoreboard.
module tb_alu;

  localparam int W = 8;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         zero;
  logic         overflow;

  alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .y        (y),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       o;
  } exp_t;

  exp_t  scb[$];
  string tag_q[$];
  int    checks = 0;
  int    fails  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] ey, input logic ez, input logic eo, input string tag);
    exp_t e;
    e.y = ey;
    e.z = ez;
    e.o = eo;
    scb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic collect();
    exp_t  e;
    string t;
    if (scb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = scb.pop_front();
      t = tag_q.pop_front();
      chk({t, " y"}, y, e.y);
      chk({t, " zero"}, {7'b0, zero}, {7'b0, e.z});
      chk({t, " ovf"}, {7'b0, overflow}, {7'b0, e.o});
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ey, input logic ez, input logic eo, input string tag);
    @(negedge clk);
    opcode = op;
    a      = av;
    b      = bv;
    push(ey, ez, eo, tag);
    @(posedge clk);
    #1;
    collect();
  endtask

  // Reference model written over plain integers.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    exp_t        e;
    int          sa;
    int          sbv;
    int          ua;
    int          ub;
    int          t;
    int unsigned sh;
    logic [7:0]  r;
    logic        o;
    sa  = int'($signed(av));
    sbv = int'($signed(bv));
    ua  = int'(av);
    ub  = int'(bv);
    sh  = int'(bv[2:0]);
    r   = 8'h00;
    o   = 1'b0;
    case (op)
      4'd0: begin
        t = sa + sbv;
        o = (t > 127) || (t < -128);
        r = (SAT && o) ? ((t > 0) ? 8'h7F : 8'h80) : 8'(t);
      end
      4'd1: begin
        t = sa - sbv;
        o = (t > 127) || (t < -128);
        r = (SAT && o) ? ((t > 0) ? 8'h7F : 8'h80) : 8'(t);
      end
      4'd2:  r = av & bv;
      4'd3:  r = av | bv;
      4'd4:  r = av ^ bv;
      4'd5:  r = ~(av | bv);
      4'd6:  r = ~(av & bv);
      4'd7:  r = ~(av ^ bv);
      4'd8:  r = 8'(ua << sh);
      4'd9:  r = 8'(ua >> sh);
      4'd10: r = 8'(sa >>> sh);
      4'd11: r = 8'((ua << sh) | (ua >> (8 - sh)));
      4'd12: r = 8'((ua >> sh) | (ua << (8 - sh)));
      4'd13: r = (sa < sbv) ? 8'd1 : 8'd0;
      4'd14: r = (ua < ub) ? 8'd1 : 8'd0;
      default: begin
        t = ua * ub;
        o = (t > 255);
        r = (SAT && o) ? 8'hFF : 8'(t);
      end
    endcase
    e.y = r;
    e.z = (r == 8'h00);
    e.o = o;
    return e;
  endfunction

  initial begin
    exp_t       e;
    logic [3:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset held with live inputs and a running clock.
    rst_n  = 1'b0;
    opcode = 4'd0;
    a      = 8'h55;
    b      = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst y", y, 8'h00);
      chk("rst zero", {7'b0, zero}, 8'h01);
      chk("rst ovf", {7'b0, overflow}, 8'h00);
    end

    // First edge after release registers the current inputs.
    rst_n = 1'b1;
    push(8'h5F, 1'b0, 1'b0, "release add");
    @(posedge clk);
    #1;
    collect();

    issue(4'd0, 8'h7F, 8'h01, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "add pos ovf");

    // Asynchronous reset between edges clears the outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst y", y, 8'h00);
    chk("async rst zero", {7'b0, zero}, 8'h01);
    chk("async rst ovf", {7'b0, overflow}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add wrap zero");
    issue(4'd1, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, 1'b0, 1'b1, "sub neg ovf");
    issue(4'd1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, "sub zero");
    issue(4'd0, 8'h80, 8'hFF, SAT ? 8'h80 : 8'h7F, 1'b0, 1'b1, "add neg ovf");
    issue(4'd1, 8'h7F, 8'hFF, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "sub pos ovf");

    issue(4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, "and");
    issue(4'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, "or");
    issue(4'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, "xor");
    issue(4'd5, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, "nor");
    issue(4'd6, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, "nand");
    issue(4'd7, 8'hF0, 8'h3C, 8'h33, 1'b0, 1'b0, "xnor");

    issue(4'd8,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, "shl");
    issue(4'd9,  8'h81, 8'h03, 8'h10, 1'b0, 1'b0, "shr");
    issue(4'd10, 8'h81, 8'h03, 8'hF0, 1'b0, 1'b0, "sar");
    issue(4'd11, 8'h81, 8'h03, 8'h0C, 1'b0, 1'b0, "rol");
    issue(4'd12, 8'h81, 8'h03, 8'h30, 1'b0, 1'b0, "ror");
    issue(4'd8,  8'h81, 8'h08, 8'h81, 1'b0, 1'b0, "shl sh0");
    issue(4'd11, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, "rol sh0");
    issue(4'd12, 8'h81, 8'h08, 8'h81, 1'b0, 1'b0, "ror sh0");
    issue(4'd10, 8'h40, 8'h02, 8'h10, 1'b0, 1'b0, "sar pos");

    issue(4'd13, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, "slt");
    issue(4'd14, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "sltu");
    issue(4'd13, 8'h42, 8'h42, 8'h00, 1'b1, 1'b0, "slt equal");
    issue(4'd15, 8'h10, 8'h10, SAT ? 8'hFF : 8'h00, !SAT, 1'b1, "mul ovf");
    issue(4'd15, 8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, "mul");

    // Randomized sweep against the integer model.
    for (int i = 0; i < 64; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      e   = model(rop, ra, rb);
      issue(rop, ra, rb, e.y, e.z, e.o, $sformatf("rnd op%0d %02h,%02h", rop, ra, rb));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit registered arithmetic/logic unit with a 16-entry opcode set.
- Each clock it computes a result from operands a and b, selected by opcode, and registers the result with zero and signed-overflow flags.
- Used as the datapath execute stage; inputs are presented one cycle and sampled on the next rising edge.

Parameters:
- WIDTH, 8, operand/result width in bits. Shift/rotate amount uses b[$clog2(WIDTH)-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  4  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- y  output  WIDTH  registered result
- zero  output  1  registered; 1 when y == 0
- overflow  output  1  registered overflow flag

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low on rst_n. While rst_n=0: y=0, zero=1, overflow=0, regardless of clk.
- Latency: all outputs are registered. Inputs present before a rising clk edge appear on y/zero/overflow after that edge (1-cycle latency). Inputs are sampled every edge; there is no handshake and no hold/enable.
- Opcode map (sh = b[2:0] for WIDTH=8):
  - 0 ADD: y=a+b; overflow = signed overflow (a,b same sign, result sign differs).
  - 1 SUB: y=a-b; overflow = signed overflow (a,b signs differ, result sign != a sign).
  - 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NAND, 7 XNOR: bitwise; overflow=0.
  - 8 SHL: y=a<<sh, zero fill.
  - 9 SHR: y=a>>sh, logical.
  - 10 SAR: arithmetic right shift, sign fill.
  - 11 ROL, 12 ROR: rotate a by sh.
  - Shift and rotate ops: overflow=0.
  - 13 SLT: y=1 if signed a<b else 0; overflow=0.
  - 14 SLTU: y=1 if unsigned a<b else 0; overflow=0.
  - 15 MUL: y = low WIDTH bits of unsigned a*b; overflow=1 when the upper WIDTH bits of the product are nonzero.
- zero is computed from the final (post-saturation) result, in the same cycle as y.
- Carry-out of ADD/SUB is not reported. Only signed overflow is reported for ADD/SUB.
- Boundaries:
  - sh=0 passes a unchanged.
  - A rotate by 0 gives a.
  - SLT with a==b gives 0.
  - Overflow is never set for non-arithmetic opcodes.
- Reset deasserting mid-stream: the first edge after rst_n rises registers the current inputs normally.
- X/undefined opcode is not permitted. All 16 codes are defined.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD and SUB saturate on signed overflow. y=0x7F when the true result is positive, 0x80 when negative. overflow is still set, and zero follows the saturated y. MUL saturates to 0xFF when overflow=1.
- Undefined: results wrap modulo 2^WIDTH as described above.

Test Plan:
- Hold rst_n=0 with a=0x55, b=0x0A, opcode=0, clock toggling -> y=0x00, zero=1, overflow=0. Release -> next edge y=0x5F, zero=0.
- ADD 0x7F+0x01 -> y=0x80, overflow=1 (with ALU_SAT_EN: y=0x7F, overflow=1). ADD 0xFF+0x01 -> y=0x00, zero=1, overflow=0.
- SUB 0x80-0x01 -> y=0x7F, overflow=1. SUB 0x33-0x33 -> y=0x00, zero=1, overflow=0.
- Logic with a=0xF0, b=0x3C:
  - AND -> 0x30.
  - OR -> 0xFC.
  - XOR -> 0xCC.
  - NOR -> 0x03.
  - NAND -> 0xCF.
  - XNOR -> 0x33.
  - overflow=0 throughout.
- Shifts with a=0x81, b=0x03:
  - SHL -> 0x08.
  - SHR -> 0x10.
  - SAR -> 0xF0.
  - ROL -> 0x0C.
  - ROR -> 0x30.
  - b=0x08 (sh=0) -> SHL gives 0x81.
- Compare/multiply:
  - SLT a=0xFF, b=0x01 -> y=0x01.
  - SLTU same operands -> y=0x00, zero=1.
  - MUL 0x10*0x10 -> y=0x00, zero=1, overflow=1.
  - MUL 0x0F*0x03 -> y=0x2D, overflow=0.
